// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge frequency meter
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_W      = 26,
    parameter int COUNT_W     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] freq,
    output logic               valid,
    output logic               ovf,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        DONE
    } state_t;

    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t              state;
    logic                sync1;
    logic                sync2;
    logic                sync3;
    logic                rise;
    logic [GATE_W-1:0]   gate_cnt;
    logic [COUNT_W-1:0]  edge_cnt;
    logic                sat;
    logic [COUNT_W-1:0]  edge_nxt;
    logic                sat_nxt;

    assign rise = sync2 & ~sync3;

    // Two-flop synchronizer plus a delay stage for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Edge count including this cycle's rise; holds at max and flags the lost edge
    always_comb begin
        edge_nxt = edge_cnt;
        sat_nxt  = sat;
        if (rise) begin
            if (edge_cnt == COUNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + 1'b1;
            end
        end
    end

    // Gate FSM: the result is loaded on entry to DONE so valid and freq line up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq     <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (en) begin
                        state <= GATE;
                        busy  <= 1'b1;
                    end
                end
                GATE: begin
                    if (!en) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else if (gate_cnt == GATE_LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        freq     <= edge_nxt;
                        ovf      <= sat_nxt;
                        valid    <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= edge_nxt;
                        sat      <= sat_nxt;
                    end
                end
                DONE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (en) begin
                        state <= GATE;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter
module tb_freq_meter;

    localparam int GC = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sig_in = 1'b0;
    logic [7:0] freq;
    logic       valid;
    logic       ovf;
    logic       busy;
    logic [6:0] freq7;
    logic       valid7;
    logic       ovf7;
    logic       busy7;

    int   cyc = 0;
    int   per = 0;
    int   ph = 0;
    int   pulse_q[$];
    int   rise_q[$];
    int   ws = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_last_freq = 0;
    logic exp_last_ovf = 1'b0;

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(10), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq(freq), .valid(valid), .ovf(ovf), .busy(busy)
    );

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(10), .COUNT_W(7)) dut7 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq(freq7), .valid(valid7), .ovf(ovf7), .busy(busy7)
    );

    initial forever #5 clk = ~clk;

    // Stimulus generator: periodic square wave or scheduled 2-cycle pulses; logs every rising edge
    initial begin
        forever begin
            logic lvl;
            @(posedge clk);
            cyc++;
            #1;
            lvl = 1'b0;
            if (per != 0) begin
                lvl = ((cyc + ph) % per) < (per / 2);
            end else begin
                foreach (pulse_q[i]) begin
                    if (cyc >= pulse_q[i] && cyc <= pulse_q[i] + 1) lvl = 1'b1;
                end
            end
            if (lvl && !sig_in) rise_q.push_back(cyc);
            sig_in = lvl;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Rises whose edge is visible (2 cycles after the input rise) inside the window [s, s+GC-1]
    function automatic int model_rises(input int s);
        int n = 0;
        foreach (rise_q[i]) begin
            if (rise_q[i] + 2 >= s && rise_q[i] + 2 <= s + GC - 1) n++;
        end
        return n;
    endfunction

    task automatic check_window(input string name, input bit chk7, input int exp_const);
        int v;
        int n;
        int budget;
        int ef;
        int ef7;
        logic eo;
        logic eo7;
        v = ws + GC;
        tick();
        budget = 1;
        while (!valid && budget < GC + 50) begin
            tick();
            budget++;
        end
        checks++;
        if (!valid) begin
            failures++;
            $display("FAIL %s timeout: valid not seen, waited %0d cycles, want pulse at cycle %0d", name, budget, v);
        end else begin
            n   = model_rises(ws);
            ef  = (n > 255) ? 255 : n;
            eo  = (n > 255);
            ef7 = (n > 127) ? 127 : n;
            eo7 = (n > 127);
            checks++;
            if (cyc !== v) begin
                failures++;
                $display("FAIL %s valid_cycle: got %0d want %0d", name, cyc, v);
            end
            checks++;
            if (freq !== 8'(ef)) begin
                failures++;
                $display("FAIL %s freq: got %0d want %0d", name, freq, ef);
            end
            checks++;
            if (ovf !== eo) begin
                failures++;
                $display("FAIL %s ovf: got %0b want %0b", name, ovf, eo);
            end
            if (exp_const >= 0) begin
                checks++;
                if (freq !== 8'(exp_const)) begin
                    failures++;
                    $display("FAIL %s freq_const: got %0d want %0d", name, freq, exp_const);
                end
            end
            if (chk7) begin
                checks++;
                if (valid7 !== 1'b1 || freq7 !== 7'(ef7) || ovf7 !== eo7) begin
                    failures++;
                    $display("FAIL %s cw7: got valid=%0b freq=%0d ovf=%0b want valid=1 freq=%0d ovf=%0b",
                             name, valid7, freq7, ovf7, ef7, eo7);
                end
            end
            exp_last_freq = ef;
            exp_last_ovf  = eo;
        end
        ws = v + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) tick();
        checks++;
        if (freq !== 8'd0 || valid !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got freq=%0d valid=%0b ovf=%0b busy=%0b want all 0", freq, valid, ovf, busy);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_en: got busy=%0b valid=%0b want 0 0", busy, valid);
        end
    endtask

    task automatic test_period20();
        per = 20;
        ph  = $urandom_range(0, 19);
        en  = 1'b1;
        ws  = cyc + 1;
        check_window("p20_w0", 1'b1, 50);
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL p20_after_done: got valid=%0b busy=%0b want 0 1", valid, busy);
        end
        check_window("p20_w1", 1'b1, 50);
    endtask

    task automatic test_saturation();
        per = 4;
        ph  = $urandom_range(0, 3);
        check_window("p4_flush", 1'b1, -1);
        check_window("p4", 1'b1, 250);
        checks++;
        if (ovf !== 1'b0 || freq7 !== 7'd127 || ovf7 !== 1'b1) begin
            failures++;
            $display("FAIL p4_sat: got ovf=%0b freq7=%0d ovf7=%0b want 0 127 1", ovf, freq7, ovf7);
        end
        per = 20;
        check_window("p20b_flush", 1'b1, -1);
        check_window("p20b", 1'b1, 50);
        checks++;
        if (freq7 !== 7'd50 || ovf7 !== 1'b0) begin
            failures++;
            $display("FAIL p20b_cw7: got freq7=%0d ovf7=%0b want 50 0", freq7, ovf7);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            per = $urandom_range(2, 40);
            ph  = $urandom_range(0, 39);
            check_window("random", 1'b1, -1);
        end
    endtask

    task automatic test_boundary();
        int e0;
        int e1;
        int e2;
        per = 0;
        pulse_q.delete();
        check_window("bnd_flush", 1'b0, -1);
        e0 = ws + GC - 1;
        e1 = e0 + GC + 1;
        e2 = e1 + GC + 1;
        pulse_q.push_back(e0 - 2);
        pulse_q.push_back(e1 - 1);
        pulse_q.push_back(e2);
        check_window("bnd_last_gate", 1'b0, 1);
        check_window("bnd_done_cycle", 1'b0, 0);
        check_window("bnd_quiet", 1'b0, 0);
        check_window("bnd_first_gate", 1'b0, 1);
    endtask

    task automatic test_zero();
        per = 0;
        check_window("zero_w0", 1'b1, 0);
        check_window("zero_w1", 1'b1, 0);
    endtask

    task automatic test_abort();
        int nv;
        per = $urandom_range(5, 30);
        ph  = $urandom_range(0, 29);
        check_window("abort_prior", 1'b1, -1);
        while (cyc < ws + 500) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: got %0b want 1", busy);
        end
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy_fall: got %0b want 0", busy);
        end
        nv = 0;
        repeat (1100) begin
            tick();
            if (valid || busy) nv++;
        end
        checks++;
        if (nv != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d valid/busy cycles want 0", nv);
        end
        checks++;
        if (freq !== 8'(exp_last_freq) || ovf !== exp_last_ovf) begin
            failures++;
            $display("FAIL abort_hold: got freq=%0d ovf=%0b want %0d %0b", freq, ovf, exp_last_freq, exp_last_ovf);
        end
        en = 1'b1;
        ws = cyc + 1;
        check_window("after_abort", 1'b1, -1);
    endtask

    task automatic test_async_reset();
        per = 0;
        while (cyc < ws + 300) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_mid_gate: got busy=%0b want 1", busy);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (freq !== 8'd0 || valid !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0 || freq7 !== 7'd0) begin
            failures++;
            $display("FAIL areset_immediate: got freq=%0d valid=%0b ovf=%0b busy=%0b want all 0", freq, valid, ovf, busy);
        end
        repeat (4) tick();
        rst = 1'b0;
        ws  = cyc + 1;
        per = $urandom_range(3, 30);
        ph  = $urandom_range(0, 29);
        tick();
        checks++;
        if (freq !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_restart: got freq=%0d busy=%0b want 0 1", freq, busy);
        end
        check_window("after_reset", 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_period20();
        test_saturation();
        test_random();
        test_boundary();
        test_zero();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: run still active at cycle %0d, want completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
